vision_judge: RTL and testbench
===============================

# vision_judge

Answer-checking and scoring controller for the vision test. It sits directly downstream of the random direction generator: it requests new directions with `en_RESTARTdown` and `en_direction`, and consumes the resulting `ran_num`. It compares each debounced direction key press against `ran_num` and advances through optotype size levels. It reports per-trial feedback and the final vision result to the display logic.

## Interface
Parameters:
- `TRIALS`, 5: trials per level (≤7)
- `PASS_MIN`, 3: hits needed to pass a level (1..`TRIALS`)
- `NUM_LEVELS`, 10: number of levels (≤15)
- `SETTLE_CYC`, 2: wait after a request pulse before keys are accepted
- `TIMEOUT_CYC`, 5000: response window per trial, in clk cycles
- `FEEDBACK_CYC`, 500: feedback display time, in cycles

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `btn_restart` in 1: one-cycle pulse; start or restart the test
- `key_up`, `key_down`, `key_left`, `key_right` in 1 each: one-cycle debounced key pulses
- `ran_num` in 3: current direction; 1=up, 2=down, 3=left, 4=right, 0=invalid
- `en_RESTARTdown` out 1: one-cycle pulse; first direction of a test
- `en_direction` out 1: one-cycle pulse; next direction
- `level` out 4: current level, 0..`NUM_LEVELS`-1
- `trial_idx` out 3: trial within the level, 0..`TRIALS`-1
- `hit_cnt` out 3: hits counted in the current level
- `fb_ok`, `fb_err` out 1 each: high during feedback
- `busy` out 1: test in progress
- `done` out 1: test finished, held until restart
- `result` out 4: number of levels passed, 0..`NUM_LEVELS`

## Operation
States:
- IDLE: all outputs are 0.
- REQ: emit one request pulse. Use `en_RESTARTdown` for the first trial after a start; use `en_direction` for every later trial. Go to SETTLE.
- SETTLE: wait `SETTLE_CYC` cycles, then go to WAIT_KEY.
- WAIT_KEY: the timeout counter runs.
  - Exactly one key pulses: a hit if its code equals `ran_num`, otherwise a miss.
  - Two or more keys pulse in the same cycle: miss.
  - `ran_num`==0 at judgement time: miss.
  - The counter reaches `TIMEOUT_CYC` with no key: miss.
  - Go to FEEDBACK.
- FEEDBACK: hold `fb_ok` (hit) or `fb_err` (miss) for `FEEDBACK_CYC` cycles. Keys are ignored. On exit:
  - If `trial_idx`<`TRIALS`-1: increment `trial_idx`, go to REQ.
  - Otherwise go to LEVEL_END.
- LEVEL_END: one cycle.
  - If `hit_cnt`≥`PASS_MIN` and `level`<`NUM_LEVELS`-1: increment `level`, clear `trial_idx` and `hit_cnt`, go to REQ.
  - If `hit_cnt`≥`PASS_MIN` at the last level: `result`=`NUM_LEVELS`, go to DONE.
  - If `hit_cnt`<`PASS_MIN`: `result`=`level`, go to DONE.
- DONE: `done`=1, `busy`=0. `level`, `hit_cnt` and `result` hold their values.

Rules:
- `btn_restart` from IDLE or DONE starts a test.
- `btn_restart` in any other state aborts the current test and starts over immediately. It has priority over key presses in the same cycle.
- Starting (or restarting) sets `level`, `trial_idx`, `hit_cnt` and `result` to 0, clears feedback, and goes to REQ with the first-trial flag set.
- `hit_cnt` saturates at `TRIALS`.
- Every trial runs, so there is no early level exit.
- Keys pressed outside WAIT_KEY are dropped; they are not queued.

## Timing
- Reset values: every output is 0; state is IDLE.
- Start latency: `btn_restart` at cycle t gives a request pulse at t+1.
- The generator updates `ran_num` on the edge after the pulse. Judgement compares against `ran_num` in the key cycle.
- Keys are accepted from cycle t+2+`SETTLE_CYC`.
- A key at cycle k sets `fb_*` high for cycles k+1 .. k+`FEEDBACK_CYC`.
- The next request pulse follows at k+`FEEDBACK_CYC`+1. When the trial ends a level, LEVEL_END adds one cycle before that pulse.
- Timeout: a miss is declared after `TIMEOUT_CYC` full WAIT_KEY cycles with no key.
- `hit_cnt` and `trial_idx` update on the cycle FEEDBACK is entered and on the cycle it is exited, respectively.
- Reset mid-operation returns to IDLE asynchronously and aborts any pending request pulse.

## Structure
- Shared package `vision_pkg`:
  - direction code constants `DIR_UP`=1, `DIR_DOWN`=2, `DIR_LEFT`=3, `DIR_RIGHT`=4
  - FSM state encoding
- One sub-module: `trial_timer`, a loadable down-counter with a `zero` flag. It is instanced once and reused for SETTLE, timeout and FEEDBACK.

## Test plan
All scenarios use `TRIALS`=5, `PASS_MIN`=3, `NUM_LEVELS`=3, `SETTLE_CYC`=2, `TIMEOUT_CYC`=20, `FEEDBACK_CYC`=4.

- Reset, then `btn_restart` at t → `en_RESTARTdown` at t+1 only. After each trial, `en_direction` pulses and `en_RESTARTdown` stays 0.
- `ran_num`=3 with `key_left` → `fb_ok` for 4 cycles and `hit_cnt`+1. `ran_num`=3 with `key_up` → `fb_err`.
- No key for 20 cycles → `fb_err`. Keys and `key_up`+`key_down` together → `fb_err`.
- All keys correct through 3 levels → `done`=1, `result`=3, `busy`=0.
- Level 0 all correct, level 1 with 2 hits → `done`, `result`=1, `level` holds 1.
- `btn_restart` mid-FEEDBACK at level 1 → `en_RESTARTdown` next cycle, `level`=0, `hit_cnt`=0. A key pressed in SETTLE is ignored.

Source files
------------

// File: rtl/vision_judge_pkg.sv
// Shared definitions for the vision test answer checker.
// Contents: direction codes as produced by the random direction generator,
// the judge FSM state encoding, and small constant/decode helpers.
package vision_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETTLE,
    ST_WAIT_KEY,
    ST_FEEDBACK,
    ST_LEVEL_END,
    ST_DONE
  } judge_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // keys = {right, left, down, up}. Only meaningful when exactly one bit is set.
  function automatic logic [2:0] key_code(input logic [3:0] keys);
    logic [2:0] code;
    code = DIR_NONE;
    if (keys[0])      code = DIR_UP;
    else if (keys[1]) code = DIR_DOWN;
    else if (keys[2]) code = DIR_LEFT;
    else if (keys[3]) code = DIR_RIGHT;
    return code;
  endfunction

endpackage

// File: rtl/vision_judge_if.sv
// Signal bundle between the vision judge and its environment
// (restart button, debounced keys, direction generator, display logic).
// slave  : the judge itself.
// master : the environment driving keys/directions and observing results.
interface vision_judge_if;
  logic       btn_restart;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic [2:0] ran_num;
  logic       en_RESTARTdown;
  logic       en_direction;
  logic [3:0] level;
  logic [2:0] trial_idx;
  logic [2:0] hit_cnt;
  logic       fb_ok;
  logic       fb_err;
  logic       busy;
  logic       done;
  logic [3:0] result;

  modport slave (
    input  btn_restart, key_up, key_down, key_left, key_right, ran_num,
    output en_RESTARTdown, en_direction, level, trial_idx, hit_cnt,
           fb_ok, fb_err, busy, done, result
  );

  modport master (
    output btn_restart, key_up, key_down, key_left, key_right, ran_num,
    input  en_RESTARTdown, en_direction, level, trial_idx, hit_cnt,
           fb_ok, fb_err, busy, done, result
  );
endinterface

// File: rtl/vision_judge_trial_timer.sv
// trial_timer: loadable down-counter shared by the settle, response-timeout
// and feedback phases. Holds at zero once it gets there.
// Ports: clk, rst (async, active-high), load + load_val (load wins over
// counting), zero (count == 0).
module trial_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/vision_judge.sv
// vision_judge: answer-checking and scoring controller for the vision test.
// Requests directions from the generator, judges each debounced key press
// against ran_num, shows per-trial feedback and walks the optotype levels.
// Ports: clk, rst (async, active-high), bus (vision_judge_if.slave) carrying
// restart/keys/ran_num in and request pulses, progress, feedback and result out.
// SETTLE_CYC, TIMEOUT_CYC and FEEDBACK_CYC must be at least 1.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | after reset, nothing running, all outputs 0
// REQ        | one-cycle direction request (first-of-test or next)
// SETTLE     | let the generator update ran_num before accepting keys
// WAIT_KEY   | response window, timer counts down to timeout
// FEEDBACK   | fb_ok/fb_err shown, keys ignored
// LEVEL_END  | one cycle: advance level or finish with result
// DONE       | test finished, results held until restart
module vision_judge
  import vision_pkg::*;
#(
  parameter int TRIALS       = 5,
  parameter int PASS_MIN     = 3,
  parameter int NUM_LEVELS   = 10,
  parameter int SETTLE_CYC   = 2,
  parameter int TIMEOUT_CYC  = 5000,
  parameter int FEEDBACK_CYC = 500
) (
  input  logic           clk,
  input  logic           rst,
  vision_judge_if.slave  bus
);

  localparam int TMR_MAX = max3(SETTLE_CYC, TIMEOUT_CYC, FEEDBACK_CYC);
  // Timer is loaded with N-1 so that the zero flag marks the Nth cycle.
  localparam int TW = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TW-1:0] SETTLE_LD  = TW'((SETTLE_CYC   > 0) ? SETTLE_CYC   - 1 : 0);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'((TIMEOUT_CYC  > 0) ? TIMEOUT_CYC  - 1 : 0);
  localparam logic [TW-1:0] FB_LD      = TW'((FEEDBACK_CYC > 0) ? FEEDBACK_CYC - 1 : 0);

  localparam logic [2:0] TRIAL_LAST = 3'(TRIALS - 1);
  localparam logic [2:0] TRIALS_C   = 3'(TRIALS);
  localparam logic [2:0] PASS_C     = 3'(PASS_MIN);
  localparam logic [3:0] LEVEL_LAST = 4'(NUM_LEVELS - 1);
  localparam logic [3:0] LEVELS_C   = 4'(NUM_LEVELS);

  judge_state_t state_q, state_d;
  logic [3:0]   level_q, level_d;
  logic [2:0]   trial_q, trial_d;
  logic [2:0]   hits_q, hits_d;
  logic [3:0]   result_q, result_d;
  logic         fb_hit_q, fb_hit_d;
  logic         first_q, first_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  logic [3:0] keys;
  logic       key_any;
  logic       key_one;
  logic       key_hit;

  trial_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign keys    = {bus.key_right, bus.key_left, bus.key_down, bus.key_up};
  assign key_any = |keys;
  assign key_one = key_any && ((keys & (keys - 4'd1)) == 4'd0);
  // ran_num==0 can never match a key code, so invalid directions score a miss.
  assign key_hit = key_one && (bus.ran_num != DIR_NONE) && (key_code(keys) == bus.ran_num);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      trial_q  <= '0;
      hits_q   <= '0;
      result_q <= '0;
      fb_hit_q <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      trial_q  <= trial_d;
      hits_q   <= hits_d;
      result_q <= result_d;
      fb_hit_q <= fb_hit_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    trial_d  = trial_q;
    hits_d   = hits_q;
    result_d = result_q;
    fb_hit_d = fb_hit_q;
    first_d  = first_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    // Restart overrides everything, including a key judged in this cycle.
    if (bus.btn_restart) begin
      state_d  = ST_REQ;
      level_d  = '0;
      trial_d  = '0;
      hits_d   = '0;
      result_d = '0;
      fb_hit_d = 1'b0;
      first_d  = 1'b1;
    end else begin
      case (state_q)
        ST_REQ: begin
          first_d  = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_LD;
            state_d  = ST_WAIT_KEY;
          end
        end
        ST_WAIT_KEY: begin
          if (key_any || tmr_zero) begin
            fb_hit_d = key_hit;
            if (key_hit && hits_q != TRIALS_C) hits_d = hits_q + 3'd1;
            tmr_load = 1'b1;
            tmr_val  = FB_LD;
            state_d  = ST_FEEDBACK;
          end
        end
        ST_FEEDBACK: begin
          if (tmr_zero) begin
            if (trial_q < TRIAL_LAST) begin
              trial_d = trial_q + 3'd1;
              state_d = ST_REQ;
            end else begin
              state_d = ST_LEVEL_END;
            end
          end
        end
        ST_LEVEL_END: begin
          if (hits_q >= PASS_C) begin
            if (level_q < LEVEL_LAST) begin
              level_d = level_q + 4'd1;
              trial_d = '0;
              hits_d  = '0;
              state_d = ST_REQ;
            end else begin
              result_d = LEVELS_C;
              state_d  = ST_DONE;
            end
          end else begin
            result_d = level_q;
            state_d  = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.en_RESTARTdown = (state_q == ST_REQ) && first_q;
  assign bus.en_direction   = (state_q == ST_REQ) && !first_q;
  assign bus.level          = level_q;
  assign bus.trial_idx      = trial_q;
  assign bus.hit_cnt        = hits_q;
  assign bus.fb_ok          = (state_q == ST_FEEDBACK) && fb_hit_q;
  assign bus.fb_err         = (state_q == ST_FEEDBACK) && !fb_hit_q;
  assign bus.busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.result         = result_q;

endmodule

// File: tb/tb_vision_judge.sv
// Self-checking bench for vision_judge. The bench plays the direction
// generator and the player; a trial-level model (hits per level, pass
// threshold, cycle offsets from the request pulse) predicts every output.
module tb_vision_judge;

  localparam int TRIALS       = 5;
  localparam int PASS_MIN     = 3;
  localparam int NUM_LEVELS   = 3;
  localparam int SETTLE_CYC   = 2;
  localparam int TIMEOUT_CYC  = 20;
  localparam int FEEDBACK_CYC = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int m_level, m_trial, m_hits;

  vision_judge_if bus();

  vision_judge #(
    .TRIALS(TRIALS), .PASS_MIN(PASS_MIN), .NUM_LEVELS(NUM_LEVELS),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .FEEDBACK_CYC(FEEDBACK_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bus.btn_restart = 1'b0;
    bus.key_up      = 1'b0;
    bus.key_down    = 1'b0;
    bus.key_left    = 1'b0;
    bus.key_right   = 1'b0;
  endtask

  task automatic set_key(input int code);
    case (code)
      1: bus.key_up    = 1'b1;
      2: bus.key_down  = 1'b1;
      3: bus.key_left  = 1'b1;
      4: bus.key_right = 1'b1;
      default: ;
    endcase
  endtask

  function automatic int wrong_dir(input int d);
    return (d % 4) + 1;
  endfunction

  // 0 correct key, 1 wrong key, 2 two keys at once, 3 no key (timeout), 4 ran_num invalid
  function automatic int pick_kind(input int mode, input int lvl, input int tr);
    case (mode)
      0: return 0;
      1: return (lvl == 0 || tr < 2) ? 0 : int'($urandom_range(1, 4));
      3: return tr;
      default: return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
    endcase
  endfunction

  task automatic start_test();
    tick();
    bus.btn_restart = 1'b1;
    tick();
  endtask

  // Called in the request cycle; returns in the last feedback cycle, or
  // right after raising btn_restart when abort is nonzero
  // (1: during feedback, 2: together with the key).
  task automatic run_trial(input int kind, input bit first, input int abort, input int dir_force);
    int  dir;
    int  d;
    bit  hit;
    chk("req_first",  8'(bus.en_RESTARTdown), 8'(first));
    chk("req_next",   8'(bus.en_direction),   8'(!first));
    chk("req_level",  8'(bus.level),          8'(m_level));
    chk("req_trial",  8'(bus.trial_idx),      8'(m_trial));
    chk("req_hits",   8'(bus.hit_cnt),        8'(m_hits));
    chk("req_fb",     8'({bus.fb_ok, bus.fb_err}), 8'd0);
    chk("req_busy",   8'(bus.busy),           8'd1);
    if (kind == 4)          dir = 0;
    else if (dir_force > 0) dir = dir_force;
    else                    dir = int'($urandom_range(1, 4));
    hit = (kind == 0);
    tick();
    bus.ran_num = 3'(dir);
    chk("settle_req", 8'({bus.en_RESTARTdown, bus.en_direction}), 8'd0);
    tick();
    if ($urandom_range(0, 1) == 1) set_key(dir);
    tick();
    if (kind == 3) begin
      for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
        chk("wait_fb", 8'({bus.fb_ok, bus.fb_err}), 8'd0);
        tick();
      end
      chk("timeout_edge_fb", 8'({bus.fb_ok, bus.fb_err}), 8'd0);
    end else begin
      d = int'($urandom_range(0, 5));
      for (int i = 0; i < d; i++) begin
        chk("wait_fb", 8'({bus.fb_ok, bus.fb_err}), 8'd0);
        tick();
      end
      chk("wait_fb", 8'({bus.fb_ok, bus.fb_err}), 8'd0);
      case (kind)
        0: set_key(dir);
        1: set_key(wrong_dir(dir));
        2: begin set_key(dir); set_key(wrong_dir(dir)); end
        default: set_key(int'($urandom_range(1, 4)));
      endcase
      if (abort == 2) begin
        bus.btn_restart = 1'b1;
        return;
      end
    end
    if (hit && m_hits < TRIALS) m_hits++;
    for (int i = 1; i <= FEEDBACK_CYC; i++) begin
      tick();
      chk("fb_ok",    8'(bus.fb_ok),   8'(hit));
      chk("fb_err",   8'(bus.fb_err),  8'(!hit));
      chk("fb_hits",  8'(bus.hit_cnt), 8'(m_hits));
      chk("fb_trial", 8'(bus.trial_idx), 8'(m_trial));
      if (abort == 1 && i == 2) begin
        bus.btn_restart = 1'b1;
        set_key(dir);
        return;
      end
      if ($urandom_range(0, 2) == 0) set_key(dir);
    end
  endtask

  // Called in the first request cycle of a test; returns in the DONE state,
  // or right after an abort request at trial 0 of level abort_lvl.
  task automatic play_test(input int mode, input int abort_lvl, input int abort_where);
    bit first;
    int kind;
    int passed;
    int df;
    first  = 1'b1;
    passed = 0;
    df     = (mode == 3) ? 3 : 0;
    for (int lvl = 0; lvl < NUM_LEVELS; lvl++) begin
      m_level = lvl;
      m_hits  = 0;
      for (int tr = 0; tr < TRIALS; tr++) begin
        m_trial = tr;
        kind = pick_kind(mode, lvl, tr);
        if (lvl == abort_lvl && tr == 0) begin
          run_trial((abort_where == 2) ? 0 : kind, first, abort_where, df);
          return;
        end
        run_trial(kind, first, 0, df);
        first = 1'b0;
        tick();
        if (tr == TRIALS - 1) begin
          chk("lvl_end_req",  8'({bus.en_RESTARTdown, bus.en_direction}), 8'd0);
          chk("lvl_end_busy", 8'(bus.busy), 8'd1);
          chk("lvl_end_fb",   8'({bus.fb_ok, bus.fb_err}), 8'd0);
          tick();
        end
      end
      if (m_hits >= PASS_MIN) passed++;
      else break;
    end
    chk("done",        8'(bus.done),   8'd1);
    chk("done_busy",   8'(bus.busy),   8'd0);
    chk("done_result", 8'(bus.result), 8'(passed));
    chk("done_level",  8'(bus.level),  8'((passed == NUM_LEVELS) ? NUM_LEVELS - 1 : passed));
    chk("done_hits",   8'(bus.hit_cnt), 8'(m_hits));
    chk("done_req",    8'({bus.en_RESTARTdown, bus.en_direction}), 8'd0);
    for (int i = 0; i < 3; i++) begin
      set_key(int'($urandom_range(1, 4)));
      tick();
      chk("done_hold",   8'(bus.done),   8'd1);
      chk("result_hold", 8'(bus.result), 8'(passed));
      chk("done_fb",     8'({bus.fb_ok, bus.fb_err}), 8'd0);
    end
  endtask

  task automatic check_restart();
    tick();
    chk("rs_first",  8'(bus.en_RESTARTdown), 8'd1);
    chk("rs_next",   8'(bus.en_direction),   8'd0);
    chk("rs_level",  8'(bus.level),          8'd0);
    chk("rs_hits",   8'(bus.hit_cnt),        8'd0);
    chk("rs_trial",  8'(bus.trial_idx),      8'd0);
    chk("rs_fb",     8'({bus.fb_ok, bus.fb_err}), 8'd0);
    chk("rs_result", 8'(bus.result),         8'd0);
    chk("rs_done",   8'(bus.done),           8'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.btn_restart = 1'b0;
    bus.key_up      = 1'b0;
    bus.key_down    = 1'b0;
    bus.key_left    = 1'b0;
    bus.key_right   = 1'b0;
    bus.ran_num     = 3'd0;
    m_level = 0; m_trial = 0; m_hits = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",    8'({bus.en_RESTARTdown, bus.en_direction}), 8'd0);
    chk("rst_status", 8'({bus.busy, bus.done, bus.fb_ok, bus.fb_err}), 8'd0);
    chk("rst_level",  8'(bus.level),     8'd0);
    chk("rst_trial",  8'(bus.trial_idx), 8'd0);
    chk("rst_hits",   8'(bus.hit_cnt),   8'd0);
    chk("rst_result", 8'(bus.result),    8'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 8'(bus.busy), 8'd0);

    // all correct through every level
    start_test();
    play_test(0, -1, 0);
    // level 0 passed, level 1 gets only two hits
    start_test();
    play_test(1, -1, 0);
    // one trial of each outcome at level 0, ran_num fixed at 3
    start_test();
    play_test(3, -1, 0);
    // restart during feedback at level 1
    start_test();
    play_test(0, 1, 1);
    check_restart();
    play_test(2, -1, 0);
    // restart in the same cycle as a correct key
    start_test();
    play_test(2, 0, 2);
    check_restart();
    play_test(2, -1, 0);
    // random runs
    for (int n = 0; n < 4; n++) begin
      start_test();
      play_test(2, -1, 0);
    end

    // asynchronous reset while a request pulse is showing
    start_test();
    chk("pre_rst_req", 8'(bus.en_RESTARTdown), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req",   8'({bus.en_RESTARTdown, bus.en_direction}), 8'd0);
    chk("arst_busy",  8'(bus.busy),  8'd0);
    chk("arst_level", 8'(bus.level), 8'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_req",  8'({bus.en_RESTARTdown, bus.en_direction}), 8'd0);
    chk("post_rst_stat", 8'({bus.busy, bus.done}), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
